// File: rtl/tone_gen_pkg.sv
// Shared definitions for the multi-channel tone generator: waveform modes,
// config register select codes and the noise LFSR polynomial.
package tone_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_NOISE  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  localparam logic [2:0] SEL_FULL_PERIOD   = 3'd0;
  localparam logic [2:0] SEL_ACTIVE_PERIOD = 3'd1;
  localparam logic [2:0] SEL_VOLUME        = 3'd2;
  localparam logic [2:0] SEL_MODE          = 3'd3;
  localparam logic [2:0] SEL_STEP          = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: double-buffered config, period counter, waveform
// datapath (square / saw / noise / off) and registered sample + wrap pulse.
module tone_channel
  import tone_gen_pkg::*;
#(
  parameter int          CNT_W = 21,
  parameter int          VOL_W = 16,
  parameter logic [15:0] SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [VOL_W-1:0] sample,
  output logic             wrap
);

  typedef struct packed {
    logic [CNT_W-1:0] full_period;
    logic [CNT_W-1:0] active_period;
    logic [VOL_W-1:0] volume;
    logic [VOL_W-1:0] step;
    mode_e            mode;
  } bank_t;

  bank_t            pend_q, pend_d;
  bank_t            act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VOL_W-1:0] level_q, level_d;
  logic [VOL_W-1:0] sample_q, sample_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             wrap_q, wrap_d;

  logic             period_end;
  logic [VOL_W:0]   saw_sum;
  logic [VOL_W-1:0] saw_next;
  logic [VOL_W-1:0] tone;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    pend_d = pend_q;
    if (cfg_we) begin
      case (cfg_sel)
        SEL_FULL_PERIOD:   pend_d.full_period   = cfg_data;
        SEL_ACTIVE_PERIOD: pend_d.active_period = cfg_data;
        SEL_VOLUME:        pend_d.volume        = cfg_data[VOL_W-1:0];
        SEL_MODE:          pend_d.mode          = mode_e'(cfg_data[1:0]);
        SEL_STEP:          pend_d.step          = cfg_data[VOL_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    // >= rather than == so a shortened period still wraps on the next cycle.
    period_end = (cnt_q >= act_q.full_period);
    saw_sum    = {1'b0, level_q} + {1'b0, act_q.step};
    saw_next   = (saw_sum > {1'b0, act_q.volume}) ? act_q.volume : saw_sum[VOL_W-1:0];

    tone = '0;
    case (act_q.mode)
      MODE_SQUARE: tone = (cnt_q < act_q.active_period) ? act_q.volume : '0;
      MODE_SAW:    tone = level_q;
      MODE_NOISE:  tone = lfsr_q[0] ? act_q.volume : '0;
      default:     tone = '0;
    endcase
  end

  always_comb begin
    act_d    = act_q;
    cnt_d    = cnt_q + CNT_W'(1);
    level_d  = saw_next;
    lfsr_d   = lfsr_q;
    wrap_d   = 1'b0;
    sample_d = tone;
    if (!enable) begin
      // Idle: track pending config so a restart picks up the latest writes.
      act_d    = pend_q;
      cnt_d    = '0;
      level_d  = '0;
      sample_d = '0;
    end else if (period_end) begin
      act_d   = pend_q;
      cnt_d   = '0;
      level_d = '0;
      lfsr_d  = lfsr_next(lfsr_q);
      wrap_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the config banks are plain flops, not a RAM, so they are reset
    // with everything else; the power-up mode and volume depend on it.
    if (rst) begin
      pend_q   <= '0;
      act_q    <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      sample_q <= '0;
      lfsr_q   <= SEED;
      wrap_q   <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      pend_q   <= pend_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      lfsr_q   <= lfsr_d;
      wrap_q   <= wrap_d;
    end
  end

  assign sample = sample_q;
  assign wrap   = wrap_q;

endmodule

// File: rtl/multi_tone_gen.sv
// N-channel tone generator: config write decode, one tone_channel per
// channel, and a registered saturating mixer feeding the audio DAC path.
module multi_tone_gen
  import tone_gen_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 21,
  parameter  int VOL_W = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [2:0]            cfg_sel,
  input  logic [CNT_W-1:0]      cfg_data,
  output logic [N_CH*VOL_W-1:0] ch_out,
  output logic [VOL_W-1:0]      mix_out,
  output logic [N_CH-1:0]       wrap
);

  localparam int SUM_W = VOL_W + $clog2(N_CH) + 1;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic ch_we;
    // Channel numbers at or above N_CH never match, so those writes drop.
    assign ch_we = cfg_we && (cfg_ch == CH_W'(k));

    tone_channel #(
      .CNT_W (CNT_W),
      .VOL_W (VOL_W),
      .SEED  (LFSR_SEED ^ 16'(k))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .cfg_we   (ch_we),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .sample   (ch_out[k*VOL_W +: VOL_W]),
      .wrap     (wrap[k])
    );
  end

  logic [SUM_W-1:0] mix_sum;
  logic [VOL_W-1:0] mix_d, mix_q;

  always_comb begin
    mix_sum = '0;
    for (int k = 0; k < N_CH; k++) begin
      mix_sum = mix_sum + SUM_W'(ch_out[k*VOL_W +: VOL_W]);
    end
    mix_d = (|mix_sum[SUM_W-1:VOL_W]) ? '1 : mix_sum[VOL_W-1:0];
    if (!enable) begin
      mix_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix_out = mix_q;

endmodule

// File: tb/tb_multi_tone_gen.sv
// Self-checking bench for multi_tone_gen: directed scenarios with literal
// expectations plus a random phase, all shadowed by a behavioural model.
module tb_multi_tone_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 21;
  localparam int VOL_W = 16;
  localparam int VMAX  = 65535;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic                  cfg_we;
  logic [1:0]            cfg_ch;
  logic [2:0]            cfg_sel;
  logic [CNT_W-1:0]      cfg_data;
  logic [N_CH*VOL_W-1:0] ch_out;
  logic [VOL_W-1:0]      mix_out;
  logic [N_CH-1:0]       wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state (pending/active config, phase, saw level, noise).
  int          p_full[N_CH], p_act[N_CH], p_vol[N_CH], p_step[N_CH], p_mode[N_CH];
  int          a_full[N_CH], a_act[N_CH], a_vol[N_CH], a_step[N_CH], a_mode[N_CH];
  int          m_cnt[N_CH], m_level[N_CH];
  logic [15:0] m_lfsr[N_CH];
  int          e_ch[N_CH];
  logic [N_CH-1:0] e_wrap;
  int          e_mix;

  multi_tone_gen #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .VOL_W (VOL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .ch_out   (ch_out),
    .mix_out  (mix_out),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic int chan(input int k);
    return int'(ch_out[k*VOL_W +: VOL_W]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      p_full[k] = 0; p_act[k] = 0; p_vol[k] = 0; p_step[k] = 0; p_mode[k] = 0;
      a_full[k] = 0; a_act[k] = 0; a_vol[k] = 0; a_step[k] = 0; a_mode[k] = 0;
      m_cnt[k] = 0; m_level[k] = 0; e_ch[k] = 0;
      m_lfsr[k] = 16'hACE1 ^ 16'(k);
    end
    e_wrap = '0;
    e_mix  = 0;
  endtask

  task automatic load_active(input int k);
    a_full[k] = p_full[k]; a_act[k] = p_act[k]; a_vol[k] = p_vol[k];
    a_step[k] = p_step[k]; a_mode[k] = p_mode[k];
  endtask

  // One clock edge of the reference, using the inputs present at that edge.
  task automatic model_step();
    int sum;
    int d;
    sum = 0;
    for (int k = 0; k < N_CH; k++) sum += e_ch[k];
    e_mix = !enable ? 0 : ((sum > VMAX) ? VMAX : sum);
    for (int k = 0; k < N_CH; k++) begin
      if (!enable) begin
        e_ch[k] = 0; e_wrap[k] = 1'b0;
        load_active(k);
        m_cnt[k] = 0; m_level[k] = 0;
      end else begin
        case (a_mode[k])
          0:       e_ch[k] = (m_cnt[k] < a_act[k]) ? a_vol[k] : 0;
          1:       e_ch[k] = m_level[k];
          2:       e_ch[k] = m_lfsr[k][0] ? a_vol[k] : 0;
          default: e_ch[k] = 0;
        endcase
        e_wrap[k] = (m_cnt[k] >= a_full[k]);
        if (e_wrap[k]) begin
          load_active(k);
          m_cnt[k] = 0; m_level[k] = 0;
          m_lfsr[k] = ref_lfsr(m_lfsr[k]);
        end else begin
          m_cnt[k]++;
          m_level[k] = (m_level[k] + a_step[k] > a_vol[k]) ? a_vol[k] : m_level[k] + a_step[k];
        end
      end
    end
    if (cfg_we && int'(cfg_ch) < N_CH) begin
      d = int'(cfg_data);
      case (cfg_sel)
        3'd0: p_full[cfg_ch] = d;
        3'd1: p_act[cfg_ch]  = d;
        3'd2: p_vol[cfg_ch]  = d & 'hFFFF;
        3'd3: p_mode[cfg_ch] = d & 3;
        3'd4: p_step[cfg_ch] = d & 'hFFFF;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    logic [63:0] packed_exp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    packed_exp = '0;
    for (int k = 0; k < N_CH; k++) packed_exp[k*VOL_W +: VOL_W] = 16'(e_ch[k]);
    check("model_ch_out", ch_out, packed_exp);
    check("model_mix_out", mix_out, 64'(e_mix));
    check("model_wrap", wrap, 64'(e_wrap));
  endtask

  task automatic drive_wr(input int ch, input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_sel  = 3'(sel);
    cfg_data = CNT_W'(data);
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    drive_wr(ch, sel, data);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic idle();
    cfg_we = 1'b0;
    cycle();
  endtask

  initial begin
    int          vol_now;
    int          exp0;
    int          prev0;
    int          saw_tab[8];
    int          sel;
    int          data;
    logic [15:0] lf;

    saw_tab = '{0, 300, 600, 900, 1000, 1000, 1000, 1000};

    // Reset state.
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ch_out", ch_out, 64'd0);
    check("reset_mix_out", mix_out, 64'd0);
    check("reset_wrap", wrap, 64'd0);
    rst = 1'b0;

    // Power-up config: silent output, full_period 0 wraps every cycle.
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      check("idle_ch_out", ch_out, 64'd0);
      check("idle_mix_out", mix_out, 64'd0);
      check("idle_wrap_every_cycle", wrap, 64'hF);
    end

    // Square on ch0, then shadowed volume writes (mid-period and on a wrap).
    enable = 1'b0;
    wr(0, 0, 9); wr(0, 1, 3); wr(0, 2, 1000); idle();
    enable = 1'b1;
    prev0 = 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 31)      drive_wr(0, 2, 500);
      else if (i == 49) drive_wr(0, 2, 200);
      else              cfg_we = 1'b0;
      cycle();
      vol_now = (i < 40) ? 1000 : ((i < 60) ? 500 : 200);
      exp0 = ((i % 10) < 3) ? vol_now : 0;
      check("square_ch0", 64'(chan(0)), 64'(exp0));
      check("square_mix", mix_out, 64'(prev0));
      check("square_wrap0", 64'(wrap[0]), 64'((i % 10) == 9));
      prev0 = exp0;
    end
    cfg_we = 1'b0;

    // Sawtooth on ch1.
    enable = 1'b0;
    wr(1, 3, 1); wr(1, 0, 7); wr(1, 4, 300); wr(1, 2, 1000); idle();
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      check("saw_ch1", 64'(chan(1)), 64'(saw_tab[i % 8]));
      check("saw_wrap1", 64'(wrap[1]), 64'((i % 8) == 7));
    end

    // Mixer saturation: four loud channels, then two.
    enable = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      wr(k, 3, 0); wr(k, 0, 3); wr(k, 1, 5); wr(k, 2, 30000);
    end
    idle();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("sat4_ch2", 64'(chan(2)), 64'd30000);
      check("sat4_mix", mix_out, (i == 0) ? 64'd0 : 64'd65535);
    end
    enable = 1'b0;
    wr(2, 3, 3); wr(3, 3, 3); idle();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("sat2_mix", mix_out, (i == 0) ? 64'd0 : 64'd60000);
    end

    // Asynchronous reset mid-period clears outputs immediately.
    #2 rst = 1'b1;
    #1;
    check("async_rst_ch_out", ch_out, 64'd0);
    check("async_rst_mix_out", mix_out, 64'd0);
    check("async_rst_wrap", wrap, 64'd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Noise on ch2 from its seed; pausing enable must not skip LFSR steps.
    wr(2, 3, 2); wr(2, 2, 1); idle();
    enable = 1'b1;
    lf = 16'hACE3;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("noise_bit", 64'(chan(2)), 64'(lf[0]));
      lf = ref_lfsr(lf);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("noise_paused", 64'(chan(2)), 64'd0);
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("noise_resume_bit", 64'(chan(2)), 64'(lf[0]));
      lf = ref_lfsr(lf);
    end

    // Random config writes and enable toggling against the model.
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) begin
        sel = int'($urandom_range(0, 7));
        case (sel)
          0, 1:    data = int'($urandom_range(0, 20));
          3:       data = int'($urandom_range(0, 3));
          default: data = int'($urandom_range(0, 65535));
        endcase
        drive_wr(int'($urandom_range(0, 3)), sel, data);
      end else begin
        cfg_we = 1'b0;
      end
      cycle();
    end
    cfg_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
